// File: rtl/ao486_io_mem_arbiter.sv
// ao486 memory / I/O port arbiter.
// Merges the core's Avalon memory and I/O masters onto one downstream Avalon
// master, maps I/O byte addresses into a word-addressed non-cacheable window,
// and steers returning read beats back to the port that issued the read.
module ao486_io_mem_arbiter #(
    parameter logic [29:0] IO_BASE   = 30'h3FFF_C000,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [29:0] mem_address,
    input  logic [31:0] mem_writedata,
    input  logic [3:0]  mem_byteenable,
    input  logic [2:0]  mem_burstcount,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic        mem_waitrequest,
    output logic        mem_readdatavalid,
    output logic [31:0] mem_readdata,

    input  logic [15:0] io_address,
    input  logic [3:0]  io_byteenable,
    input  logic        io_read,
    input  logic        io_write,
    input  logic [31:0] io_writedata,
    output logic        io_waitrequest,
    output logic        io_readdatavalid,
    output logic [31:0] io_readdata,

    output logic [29:0] down_address,
    output logic [31:0] down_writedata,
    output logic [3:0]  down_byteenable,
    output logic [2:0]  down_burstcount,
    output logic        down_write,
    output logic        down_read,
    input  logic        down_waitrequest,
    input  logic        down_readdatavalid,
    input  logic [31:0] down_readdata,

    output logic        err_stray
);

    typedef enum logic [2:0] {
        IDLE,
        MEM_CMD,
        IO_CMD,
        MEM_RD,
        IO_RD
    } state_t;

    state_t     state;
    logic       last_io;   // 1: the most recent grant went to the I/O port
    logic [2:0] count;     // read beats still owed to the owning port

    logic mem_req;
    logic io_req;
    logic reading;
    logic unused_io_lsb;

    assign mem_req       = mem_read | mem_write;
    assign io_req        = io_read | io_write;
    assign reading       = (state == MEM_RD) || (state == IO_RD);
    // I/O accesses are word granular downstream; byte lanes come from byteenable
    assign unused_io_lsb = ^io_address[1:0];

    // Arbitration, command acceptance, beat counting and stray-beat flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_io   <= 1'b1;
            count     <= '0;
            err_stray <= 1'b0;
        end else begin
            if (down_readdatavalid && !reading) begin
                err_stray <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mem_req && (!io_req || last_io)) begin
                        state   <= MEM_CMD;
                        last_io <= 1'b0;
                    end else if (io_req) begin
                        state   <= IO_CMD;
                        last_io <= 1'b1;
                    end
                end
                MEM_CMD: begin
                    if (!mem_req) begin
                        state <= IDLE;
                    end else if (!down_waitrequest) begin
                        if (mem_read) begin
                            count <= (mem_burstcount == 3'd0) ? 3'd1 : mem_burstcount;
                            state <= MEM_RD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                IO_CMD: begin
                    if (!io_req) begin
                        state <= IDLE;
                    end else if (!down_waitrequest) begin
                        if (io_read) begin
                            count <= 3'd1;
                            state <= IO_RD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                MEM_RD, IO_RD: begin
                    if (down_readdatavalid) begin
                        count <= count - 3'd1;
                        if (count == 3'd1) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream command mux and upstream handshake / read-beat steering
    always_comb begin
        down_address      = '0;
        down_writedata    = '0;
        down_byteenable   = '0;
        down_burstcount   = '0;
        down_write        = 1'b0;
        down_read         = 1'b0;
        mem_waitrequest   = 1'b1;
        io_waitrequest    = 1'b1;
        mem_readdatavalid = 1'b0;
        io_readdatavalid  = 1'b0;
        mem_readdata      = down_readdata;
        io_readdata       = down_readdata;
        case (state)
            MEM_CMD: begin
                down_address    = mem_address;
                down_writedata  = mem_writedata;
                down_byteenable = mem_byteenable;
                down_burstcount = mem_burstcount;
                down_write      = mem_write;
                down_read       = mem_read;
                mem_waitrequest = down_waitrequest;
            end
            IO_CMD: begin
                down_address    = {IO_BASE[29:14], io_address[15:2]};
                down_writedata  = io_writedata;
                down_byteenable = io_byteenable;
                down_burstcount = 3'd1;
                down_read       = io_read;
                down_write      = io_write & ~io_read;
                io_waitrequest  = down_waitrequest;
            end
            MEM_RD:  mem_readdatavalid = down_readdatavalid;
            IO_RD:   io_readdatavalid  = down_readdatavalid;
            default: ;
        endcase
    end

    // Accepted memory read bursts must not exceed the supported length
    always_ff @(posedge clk) begin
        if (!rst && state == MEM_CMD && mem_read && !down_waitrequest) begin
            assert (32'(mem_burstcount) <= MAX_BURST);
        end
    end

endmodule

// File: tb/tb_ao486_io_mem_arbiter.sv
// Self-checking bench for ao486_io_mem_arbiter: a memory-model slave sits on
// the downstream port, upstream transactions are checked against an
// expected-memory model and the round-robin grant rule.
module tb_ao486_io_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [2:0]  mem_burstcount;
    logic        mem_write, mem_read;
    logic        mem_waitrequest, mem_readdatavalid;
    logic [31:0] mem_readdata;
    logic [15:0] io_address;
    logic [3:0]  io_byteenable;
    logic        io_read, io_write;
    logic [31:0] io_writedata;
    logic        io_waitrequest, io_readdatavalid;
    logic [31:0] io_readdata;
    logic [29:0] down_address;
    logic [31:0] down_writedata;
    logic [3:0]  down_byteenable;
    logic [2:0]  down_burstcount;
    logic        down_write, down_read;
    logic        down_waitrequest, down_readdatavalid;
    logic [31:0] down_readdata;
    logic        err_stray;

    always #5 clk = ~clk;

    ao486_io_mem_arbiter #(.IO_BASE(30'h3FFF_C000), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_byteenable(mem_byteenable), .mem_burstcount(mem_burstcount),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_waitrequest(mem_waitrequest), .mem_readdatavalid(mem_readdatavalid),
        .mem_readdata(mem_readdata),
        .io_address(io_address), .io_byteenable(io_byteenable),
        .io_read(io_read), .io_write(io_write), .io_writedata(io_writedata),
        .io_waitrequest(io_waitrequest), .io_readdatavalid(io_readdatavalid),
        .io_readdata(io_readdata),
        .down_address(down_address), .down_writedata(down_writedata),
        .down_byteenable(down_byteenable), .down_burstcount(down_burstcount),
        .down_write(down_write), .down_read(down_read),
        .down_waitrequest(down_waitrequest), .down_readdatavalid(down_readdatavalid),
        .down_readdata(down_readdata),
        .err_stray(err_stray)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- downstream slave (memory model) ----------------
    logic [31:0] smem [logic [29:0]];
    logic [31:0] emem [logic [29:0]];
    logic [31:0] q [$];
    logic [29:0] log_addr [$];
    logic        s_wait = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_data = '0;
    bit          hold = 1'b0;
    bit          gapless = 1'b1;
    int          cfg_high = 1;   // 0: random stall length
    int          stall_left = 0;

    assign down_waitrequest   = s_wait;
    assign down_readdatavalid = s_valid | m_valid;
    assign down_readdata      = m_valid ? m_data : s_data;

    function automatic logic [31:0] dflt(input logic [29:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] sread(input logic [29:0] a);
        return smem.exists(a) ? smem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] model_read(input logic [29:0] a);
        return emem.exists(a) ? emem[a] : dflt(a);
    endfunction

    task automatic slave_accept(input logic [29:0] a, input logic rd, input logic [2:0] bc,
                                input logic [31:0] wd, input logic [3:0] be);
        int n;
        log_addr.push_back(a);
        if (rd) begin
            n = (bc == 3'd0) ? 1 : int'(bc);
            for (int i = 0; i < n; i++) q.push_back(sread(a + 30'(i)));
        end else begin
            smem[a] = merge(sread(a), wd, be);
        end
    endtask

    always @(posedge clk) begin
        if (!hold && q.size() > 0 && (gapless || $urandom_range(0, 1) == 1)) begin
            s_valid <= 1'b1;
            s_data  <= q.pop_front();
        end else begin
            s_valid <= 1'b0;
        end
        if ((down_read || down_write) && !s_wait) begin
            slave_accept(down_address, down_read, down_burstcount, down_writedata, down_byteenable);
            s_wait <= 1'b1;
        end else if (down_read || down_write) begin
            if (stall_left == 0) s_wait <= 1'b0;
            else stall_left <= stall_left - 1;
        end else begin
            s_wait     <= 1'b1;
            stall_left <= (cfg_high == 0) ? int'($urandom_range(0, 2)) : cfg_high - 1;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic prime(input logic [29:0] a, input logic [31:0] d);
        smem[a] = d;
        emem[a] = d;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_down_addr"}, 32'(down_address), 0);
        chk({tag, "_down_wdata"}, down_writedata, 0);
        chk({tag, "_down_be"}, 32'(down_byteenable), 0);
        chk({tag, "_down_bc"}, 32'(down_burstcount), 0);
        chk({tag, "_down_rw"}, {30'd0, down_read, down_write}, 0);
        chk({tag, "_waits"}, {30'd0, mem_waitrequest, io_waitrequest}, 32'h3);
        chk({tag, "_rdv"}, {30'd0, mem_readdatavalid, io_readdatavalid}, 0);
        chk({tag, "_err"}, 32'(err_stray), 0);
    endtask

    // One upstream transaction; called just after a rising edge.
    task automatic txn(input bit is_io, input bit rd, input bit rwboth,
                       input logic [29:0] addr, input logic [2:0] bc,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [29:0] exp_addr, input logic [2:0] exp_bc,
                       input string tag, output int waits, output int done_cyc);
        int  nb, got;
        bit  acc;
        if (is_io) begin
            io_address = addr[15:0]; io_byteenable = be; io_writedata = wd;
            io_read = rd; io_write = !rd || rwboth;
        end else begin
            mem_address = addr; mem_burstcount = bc; mem_byteenable = be;
            mem_writedata = wd; mem_read = rd; mem_write = !rd;
        end
        waits = 0;
        acc = 1'b0;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if ((is_io ? io_waitrequest : mem_waitrequest) == 1'b0) begin
                acc = 1'b1;
                chk({tag, "_addr"}, 32'(down_address), 32'(exp_addr));
                chk({tag, "_bc"}, 32'(down_burstcount), 32'(exp_bc));
                chk({tag, "_rw"}, {30'd0, down_read, down_write}, {30'd0, rd, !rd});
                chk({tag, "_other_wait"}, 32'(is_io ? mem_waitrequest : io_waitrequest), 1);
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (is_io) begin io_read = 1'b0; io_write = 1'b0; end
        else begin mem_read = 1'b0; mem_write = 1'b0; end
        chk({tag, "_accepted"}, 32'(acc), 1);
        if (acc && rd) begin
            nb = is_io ? 1 : ((bc == 3'd0) ? 1 : int'(bc));
            got = 0;
            for (int c = 0; c < 300 && got < nb; c++) begin
                @(negedge clk);
                if ((is_io ? io_readdatavalid : mem_readdatavalid) == 1'b1) begin
                    chk({tag, "_data"}, is_io ? io_readdata : mem_readdata,
                        model_read(exp_addr + 30'(got)));
                    chk({tag, "_other_rdv"}, 32'(is_io ? mem_readdatavalid : io_readdatavalid), 0);
                    got++;
                end
            end
            chk({tag, "_beats"}, 32'(got), 32'(nb));
        end else if (acc) begin
            emem[exp_addr] = merge(model_read(exp_addr), wd, be);
        end
        done_cyc = cyc;
    endtask

    typedef struct {
        bit          is_io;
        bit          rd;
        bit          rwboth;
        logic [29:0] addr;
        logic [2:0]  bc;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [29:0] exp_addr;
        logic [2:0]  exp_bc;
        int          high;
        int          exp_waits;   // 0: not checked
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [7];
        int   w0, w1, d0, d1, got;
        bit   acc, seen, model_last_io, first_io, mode_io;
        logic [29:0] ma, ea;
        logic [15:0] ia;
        logic [2:0]  bc;
        int   mode;

        tbl[0] = '{1, 0, 0, 30'h3F8,  3'd0, 4'b0001, 32'h0000_0055, 30'h3FFF_C0FE, 3'd1, 2, 3};
        tbl[1] = '{1, 1, 0, 30'h060,  3'd0, 4'b1111, 32'h0,         30'h3FFF_C018, 3'd1, 5, 6};
        tbl[2] = '{1, 1, 0, 30'h3F8,  3'd0, 4'b1111, 32'h0,         30'h3FFF_C0FE, 3'd1, 1, 2};
        tbl[3] = '{0, 0, 0, 30'h040,  3'd2, 4'b1111, 32'hDEAD_BEEF, 30'h040,       3'd2, 1, 2};
        tbl[4] = '{0, 1, 0, 30'h040,  3'd0, 4'b1111, 32'h0,         30'h040,       3'd0, 1, 0};
        tbl[5] = '{1, 1, 1, 30'h010,  3'd0, 4'b0011, 32'h1111_2222, 30'h3FFF_C004, 3'd1, 2, 0};
        tbl[6] = '{0, 1, 0, 30'h100,  3'd4, 4'b1111, 32'h0,         30'h100,       3'd4, 1, 0};

        for (int i = 0; i < 4; i++) prime(30'h100 + 30'(i), 32'hA0 + 32'(i));
        prime(30'h3FFF_C018, 32'h1234);

        rst = 1'b1;
        mem_address = '0; mem_writedata = '0; mem_byteenable = '0; mem_burstcount = '0;
        mem_write = 1'b0; mem_read = 1'b0;
        io_address = '0; io_byteenable = '0; io_read = 1'b0; io_write = 1'b0; io_writedata = '0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // simultaneous reads after reset: memory port wins, then I/O
        log_addr.delete();
        cfg_high = 1;
        gapless = 1;
        fork
            txn(0, 1, 0, 30'h100, 3'd4, 4'hF, 32'h0, 30'h100, 3'd4, "both_mem", w0, d0);
            txn(1, 1, 0, 30'h060, 3'd0, 4'hF, 32'h0, 30'h3FFF_C018, 3'd1, "both_io", w1, d1);
        join
        chk("both_order", 32'(d1 > d0), 1);
        chk("both_first_grant", (log_addr.size() > 0) ? 32'(log_addr[0]) : 32'hFFFF_FFFF, 32'h100);
        repeat (2) @(posedge clk);
        #1;

        // table vectors
        for (int i = 0; i < 7; i++) begin
            cfg_high = tbl[i].high;
            repeat (2) @(posedge clk);
            #1;
            txn(tbl[i].is_io, tbl[i].rd, tbl[i].rwboth, tbl[i].addr, tbl[i].bc, tbl[i].be,
                tbl[i].wd, tbl[i].exp_addr, tbl[i].exp_bc, $sformatf("vec%0d", i), w0, d0);
            if (tbl[i].exp_waits != 0) chk($sformatf("vec%0d_waits", i), 32'(w0), 32'(tbl[i].exp_waits));
        end
        repeat (2) @(posedge clk);
        #1;

        // stray beat in IDLE
        chk("stray_pre_err", 32'(err_stray), 0);
        m_valid = 1'b1;
        m_data = 32'hBAD0_0001;
        @(negedge clk);
        chk("stray_rdv", {30'd0, mem_readdatavalid, io_readdatavalid}, 0);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        chk("stray_err_set", 32'(err_stray), 1);
        repeat (4) @(posedge clk);
        #1;
        chk("stray_err_sticky", 32'(err_stray), 1);

        // reset in the middle of a 4-beat memory burst
        prime(30'h200, 32'hC0); prime(30'h201, 32'hC1); prime(30'h202, 32'hC2); prime(30'h203, 32'hC3);
        cfg_high = 1;
        gapless = 1;
        mem_address = 30'h200; mem_burstcount = 3'd4; mem_byteenable = 4'hF; mem_read = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            if (!mem_waitrequest) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        mem_read = 1'b0;
        chk("rstb_accepted", 32'(acc), 1);
        got = 0;
        for (int c = 0; c < 50 && got < 2; c++) begin
            @(negedge clk);
            if (mem_readdatavalid) begin
                chk("rstb_data", mem_readdata, model_read(30'h200 + 30'(got)));
                got++;
            end
        end
        chk("rstb_beats", 32'(got), 2);
        hold = 1'b1;
        rst = 1'b1;
        #1;
        chk_reset_values("rstb_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_readdatavalid || io_readdatavalid) seen = 1'b1;
        end
        chk("rstb_late_rdv", 32'(seen), 0);
        chk("rstb_late_err", 32'(err_stray), 1);
        chk("rstb_queue_drained", 32'(q.size()), 0);
        @(posedge clk);
        #1;
        txn(1, 1, 0, 30'h060, 3'd0, 4'hF, 32'h0, 30'h3FFF_C018, 3'd1, "rstb_io", w0, d0);
        model_last_io = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // randomized traffic against the expected-memory model
        cfg_high = 0;
        gapless = 0;
        for (int it = 0; it < 40; it++) begin
            mode = int'($urandom_range(0, 2));
            ma = 30'($urandom_range(0, 255));
            bc = 3'($urandom_range(0, 4));
            ia = 16'($urandom_range(0, 127));
            ea = 30'h3FFF_C000 + 30'(ia >> 2);
            w0 = int'($urandom_range(0, 1));   // mem read?
            w1 = int'($urandom_range(0, 1));   // io read?
            if (w0 == 0 && bc == 3'd0) bc = 3'd1;
            log_addr.delete();
            if (mode == 2) begin
                first_io = !model_last_io;
                fork
                    txn(0, w0[0], 0, ma, bc, 4'($urandom_range(1, 15)), $urandom, ma, bc,
                        $sformatf("rnd%0d_mem", it), d0, d1);
                    txn(1, w1[0], 0, {14'd0, ia}, 3'd0, 4'($urandom_range(1, 15)), $urandom,
                        ea, 3'd1, $sformatf("rnd%0d_io", it), d0, d1);
                join
                chk($sformatf("rnd%0d_grant", it),
                    (log_addr.size() > 0) ? 32'(log_addr[0][29]) : 32'hFFFF_FFFF, 32'(first_io));
                model_last_io = !first_io;
            end else begin
                mode_io = (mode == 1);
                if (mode_io)
                    txn(1, w1[0], 0, {14'd0, ia}, 3'd0, 4'($urandom_range(1, 15)), $urandom,
                        ea, 3'd1, $sformatf("rnd%0d_io", it), d0, d1);
                else
                    txn(0, w0[0], 0, ma, bc, 4'($urandom_range(1, 15)), $urandom, ma, bc,
                        $sformatf("rnd%0d_mem", it), d0, d1);
                model_last_io = mode_io;
            end
            repeat (2) @(posedge clk);
            #1;
        end
        chk("final_err_sticky", 32'(err_stray), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
